// File: rtl/brick_collision_scanner_pkg.sv
// Shared encodings and defaults for the brick collision scanner.
package brick_pkg;

    // Contact face reported with a brick hit
    localparam logic [1:0] FACE_NONE   = 2'b00;
    localparam logic [1:0] FACE_SIDE   = 2'b01;  // reverse x
    localparam logic [1:0] FACE_TB     = 2'b10;  // reverse y
    localparam logic [1:0] FACE_CORNER = 2'b11;  // reverse both

    // Paddle contact zone
    localparam logic [1:0] ZONE_LEFT   = 2'b00;
    localparam logic [1:0] ZONE_CENTRE = 2'b01;
    localparam logic [1:0] ZONE_RIGHT  = 2'b10;

    // Default geometry
    localparam int DEF_PITCH_X = 128;
    localparam int DEF_PITCH_Y = 24;
    localparam int DEF_CW      = 10;

    // Scanner sequencing
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_PADDLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/brick_collision_scanner_if.sv
// Bundle of positions, controls and results between the scanner and its
// neighbours. The scanner is the slave; position/score logic is the master.
// Control pulses (frame_tick, load_level) and result pulses (hit_valid,
// paddle_hit, scan_done) are single-cycle strobes with no back-pressure:
// a pulse is consumed on the one rising edge where it is high.
interface brick_collision_scanner_if
    import brick_pkg::*;
#(
    parameter int N  = 10,
    parameter int IW = 4,
    parameter int CW = 10
) ();
    logic          frame_tick;
    logic          load_level;
    logic [CW-1:0] ball_x;
    logic [CW-1:0] ball_y;
    logic [CW-1:0] ball_w;
    logic [CW-1:0] ball_h;
    logic [CW-1:0] paddle_x;
    logic [CW-1:0] paddle_y;
    logic [CW-1:0] paddle_w;
    logic [CW-1:0] paddle_h;
    logic [CW-1:0] grid_x0;
    logic [CW-1:0] grid_y0;
    logic [CW-1:0] blk_w;
    logic [CW-1:0] blk_h;
    logic [N-1:0]  alive_mask;
    logic [IW:0]   blocks_left;
    logic          busy;
    logic          hit_valid;
    logic [IW-1:0] hit_idx;
    logic [1:0]    hit_face;
    logic          paddle_hit;
    logic [1:0]    paddle_zone;
    logic          scan_done;
    logic          overrun;
    state_t        state;       // debug view of the sequencer

    modport master (
        output frame_tick, load_level,
        output ball_x, ball_y, ball_w, ball_h,
        output paddle_x, paddle_y, paddle_w, paddle_h,
        output grid_x0, grid_y0, blk_w, blk_h,
        input  alive_mask, blocks_left, busy,
        input  hit_valid, hit_idx, hit_face,
        input  paddle_hit, paddle_zone, scan_done, overrun, state
    );

    modport slave (
        input  frame_tick, load_level,
        input  ball_x, ball_y, ball_w, ball_h,
        input  paddle_x, paddle_y, paddle_w, paddle_h,
        input  grid_x0, grid_y0, blk_w, blk_h,
        output alive_mask, blocks_left, busy,
        output hit_valid, hit_idx, hit_face,
        output paddle_hit, paddle_zone, scan_done, overrun, state
    );
endinterface

// File: rtl/brick_collision_scanner_rect_overlap.sv
// Axis-aligned rectangle overlap with penetration depths. Sums carry one
// extra bit so a rectangle touching the top of the coordinate range does not
// wrap. ox/oy are only meaningful when hit is set.
module rect_overlap #(
    parameter int W = 11
) (
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] aw,
    input  logic [W-1:0] ah,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] bw,
    input  logic [W-1:0] bh,
    output logic         hit,
    output logic [W:0]   ox,
    output logic [W:0]   oy
);
    logic [W:0] a_l, a_r, a_t, a_b;
    logic [W:0] b_l, b_r, b_t, b_b;
    logic [W:0] dx0, dx1, dy0, dy1;

    // Edge positions, strict-inequality overlap and the shallower depth per axis
    always_comb begin
        a_l = {1'b0, ax};
        a_r = {1'b0, ax} + {1'b0, aw};
        a_t = {1'b0, ay};
        a_b = {1'b0, ay} + {1'b0, ah};
        b_l = {1'b0, bx};
        b_r = {1'b0, bx} + {1'b0, bw};
        b_t = {1'b0, by};
        b_b = {1'b0, by} + {1'b0, bh};
        hit = (a_l < b_r) && (a_r > b_l) && (a_t < b_b) && (a_b > b_t);
        dx0 = a_r - b_l;
        dx1 = b_r - a_l;
        dy0 = a_b - b_t;
        dy1 = b_b - a_t;
        ox  = (dx0 < dx1) ? dx0 : dx1;
        oy  = (dy0 < dy1) ? dy0 : dy1;
    end
endmodule

// File: rtl/brick_collision_scanner.sv
// Brick grid collision scanner: after each frame_tick it walks the grid one
// brick per clock, keeps the first live brick the ball overlaps, checks the
// paddle, then reports everything in one cycle and removes the hit brick.
module brick_collision_scanner
    import brick_pkg::*;
#(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 2,
    parameter int PITCH_X  = DEF_PITCH_X,
    parameter int PITCH_Y  = DEF_PITCH_Y,
    parameter int CW       = DEF_CW
) (
    input logic                       clk,
    input logic                       rst,
    brick_collision_scanner_if.slave  bus
);
    localparam int N   = NUM_COLS * NUM_ROWS;
    localparam int IW  = $clog2(N);
    localparam int CLW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int PW  = CW + 1;   // brick origins can run past the screen edge

    state_t        state;
    logic [IW-1:0] idx;
    logic [CLW-1:0] col;
    logic [PW-1:0] cur_x;
    logic [PW-1:0] cur_y;

    // Ball and paddle as they were when the frame started
    logic [CW-1:0] sh_ball_x, sh_ball_y, sh_ball_w, sh_ball_h;
    logic [CW-1:0] sh_pad_x, sh_pad_y, sh_pad_w, sh_pad_h;

    // First hit found during the current scan
    logic          found;
    logic [IW-1:0] found_idx;
    logic [1:0]    found_face;

    logic [N-1:0]  alive;
    logic          busy_r;
    logic          hit_valid_r;
    logic [IW-1:0] hit_idx_r;
    logic [1:0]    hit_face_r;
    logic          paddle_hit_r;
    logic [1:0]    paddle_zone_r;
    logic          scan_done_r;
    logic          overrun_r;

    logic          brick_hit;
    logic [PW:0]   brick_ox, brick_oy;
    logic [1:0]    brick_face;
    logic          pad_hit;
    logic [PW:0]   pad_ox_unused, pad_oy_unused;
    logic [PW-1:0] ball_cx, pad_off, pad_quarter, pad_right;
    logic [1:0]    zone;
    logic [IW:0]   live_count;

    rect_overlap #(.W(PW)) u_brick (
        .ax ({1'b0, sh_ball_x}),
        .ay ({1'b0, sh_ball_y}),
        .aw ({1'b0, sh_ball_w}),
        .ah ({1'b0, sh_ball_h}),
        .bx (cur_x),
        .by (cur_y),
        .bw ({1'b0, bus.blk_w}),
        .bh ({1'b0, bus.blk_h}),
        .hit(brick_hit),
        .ox (brick_ox),
        .oy (brick_oy)
    );

    rect_overlap #(.W(PW)) u_paddle (
        .ax ({1'b0, sh_ball_x}),
        .ay ({1'b0, sh_ball_y}),
        .aw ({1'b0, sh_ball_w}),
        .ah ({1'b0, sh_ball_h}),
        .bx ({1'b0, sh_pad_x}),
        .by ({1'b0, sh_pad_y}),
        .bw ({1'b0, sh_pad_w}),
        .bh ({1'b0, sh_pad_h}),
        .hit(pad_hit),
        .ox (pad_ox_unused),
        .oy (pad_oy_unused)
    );

    // Shallower penetration picks the face to bounce off; a tie is a corner
    always_comb begin
        brick_face = FACE_CORNER;
        if (brick_ox < brick_oy) begin
            brick_face = FACE_SIDE;
        end else if (brick_oy < brick_ox) begin
            brick_face = FACE_TB;
        end
    end

    // Ball centre offset from the paddle's left edge, clamped at zero, into a zone
    always_comb begin
        ball_cx     = {1'b0, sh_ball_x} + {2'b00, sh_ball_w[CW-1:1]};
        pad_off     = (ball_cx > {1'b0, sh_pad_x}) ? (ball_cx - {1'b0, sh_pad_x}) : '0;
        pad_quarter = {3'b000, sh_pad_w[CW-1:2]};
        pad_right   = {1'b0, sh_pad_w} - pad_quarter;
        zone        = ZONE_CENTRE;
        if (pad_off < pad_quarter) begin
            zone = ZONE_LEFT;
        end else if (pad_off >= pad_right) begin
            zone = ZONE_RIGHT;
        end
    end

    // Number of bricks still standing
    always_comb begin
        live_count = '0;
        for (int i = 0; i < N; i++) begin
            live_count = live_count + {{IW{1'b0}}, alive[i]};
        end
    end

    // Sequencer: scan, paddle check, report; load_level overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            col           <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            sh_ball_x     <= '0;
            sh_ball_y     <= '0;
            sh_ball_w     <= '0;
            sh_ball_h     <= '0;
            sh_pad_x      <= '0;
            sh_pad_y      <= '0;
            sh_pad_w      <= '0;
            sh_pad_h      <= '0;
            found         <= 1'b0;
            found_idx     <= '0;
            found_face    <= FACE_NONE;
            alive         <= '1;
            busy_r        <= 1'b0;
            hit_valid_r   <= 1'b0;
            hit_idx_r     <= '0;
            hit_face_r    <= FACE_NONE;
            paddle_hit_r  <= 1'b0;
            paddle_zone_r <= ZONE_LEFT;
            scan_done_r   <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (bus.load_level) begin
            state        <= ST_IDLE;
            idx          <= '0;
            found        <= 1'b0;
            alive        <= '1;
            busy_r       <= 1'b0;
            hit_valid_r  <= 1'b0;
            paddle_hit_r <= 1'b0;
            scan_done_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            hit_valid_r  <= 1'b0;
            paddle_hit_r <= 1'b0;
            scan_done_r  <= 1'b0;
            if (bus.frame_tick && (state != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        state     <= ST_SCAN;
                        busy_r    <= 1'b1;
                        idx       <= '0;
                        col       <= '0;
                        cur_x     <= {1'b0, bus.grid_x0};
                        cur_y     <= {1'b0, bus.grid_y0};
                        found     <= 1'b0;
                        sh_ball_x <= bus.ball_x;
                        sh_ball_y <= bus.ball_y;
                        sh_ball_w <= bus.ball_w;
                        sh_ball_h <= bus.ball_h;
                        sh_pad_x  <= bus.paddle_x;
                        sh_pad_y  <= bus.paddle_y;
                        sh_pad_w  <= bus.paddle_w;
                        sh_pad_h  <= bus.paddle_h;
                    end
                end
                ST_SCAN: begin
                    if (!found && alive[idx] && brick_hit) begin
                        found      <= 1'b1;
                        found_idx  <= idx;
                        found_face <= brick_face;
                    end
                    // Walk the grid by adding pitches instead of multiplying
                    if (col == CLW'(NUM_COLS - 1)) begin
                        col   <= '0;
                        cur_x <= {1'b0, bus.grid_x0};
                        cur_y <= cur_y + PW'(PITCH_Y);
                    end else begin
                        col   <= col + 1'b1;
                        cur_x <= cur_x + PW'(PITCH_X);
                    end
                    if (idx == IW'(N - 1)) begin
                        state <= ST_PADDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_PADDLE: begin
                    state        <= ST_REPORT;
                    scan_done_r  <= 1'b1;
                    hit_valid_r  <= found;
                    paddle_hit_r <= pad_hit;
                    if (found) begin
                        hit_idx_r  <= found_idx;
                        hit_face_r <= found_face;
                    end
                    if (pad_hit) begin
                        paddle_zone_r <= zone;
                    end
                end
                ST_REPORT: begin
                    if (hit_valid_r) begin
                        alive[hit_idx_r] <= 1'b0;
                    end
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    idx    <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alive_mask  = alive;
    assign bus.blocks_left = live_count;
    assign bus.busy        = busy_r;
    assign bus.hit_valid   = hit_valid_r;
    assign bus.hit_idx     = hit_idx_r;
    assign bus.hit_face    = hit_face_r;
    assign bus.paddle_hit  = paddle_hit_r;
    assign bus.paddle_zone = paddle_zone_r;
    assign bus.scan_done   = scan_done_r;
    assign bus.overrun     = overrun_r;
    assign bus.state       = state;

endmodule

// File: tb/tb_brick_collision_scanner.sv
// Bench for brick_collision_scanner: directed frames plus random frames,
// each compared against a geometric model of the grid kept here.
module tb_brick_collision_scanner;
    localparam int NC = 5;
    localparam int NR = 2;
    localparam int PX = 128;
    localparam int PY = 24;
    localparam int CW = 10;
    localparam int N  = NC * NR;
    localparam int IW = 4;

    typedef struct packed {
        logic       hv;
        logic [3:0] hi;
        logic [1:0] hf;
        logic       ph;
        logic [1:0] zone;
    } res_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Model state
    bit   m_alive [N];
    bit   m_overrun;
    int   g_x0, g_y0, g_bw, g_bh;
    res_t exp_q [$];

    brick_collision_scanner_if #(.N(N), .IW(IW), .CW(CW)) bus ();

    brick_collision_scanner #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .PITCH_X(PX), .PITCH_Y(PY), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ovl(input int ax, ay, aw, ah, bx, by, bw, bh);
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = m_alive[i];
        return m;
    endfunction

    function automatic int model_left();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alive[i]);
        return c;
    endfunction

    // Geometric reference: brick i sits at column i%NC, row i/NC
    task automatic model_frame(input int bx, by, bw, bh, px, py, pw, ph, output res_t r);
        int x, y, ox, oy, cx, off, q;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = g_x0 + (i % NC) * PX;
            y = g_y0 + (i / NC) * PY;
            if (!r.hv && m_alive[i] && ovl(bx, by, bw, bh, x, y, g_bw, g_bh)) begin
                r.hv = 1'b1;
                r.hi = 4'(i);
                ox = (bx + bw - x < x + g_bw - bx) ? (bx + bw - x) : (x + g_bw - bx);
                oy = (by + bh - y < y + g_bh - by) ? (by + bh - y) : (y + g_bh - by);
                r.hf = (ox < oy) ? 2'b01 : ((oy < ox) ? 2'b10 : 2'b11);
            end
        end
        r.ph = ovl(bx, by, bw, bh, px, py, pw, ph);
        cx  = bx + bw / 2;
        off = (cx > px) ? cx - px : 0;
        q   = pw / 4;
        r.zone = (off < q) ? 2'b00 : ((off >= pw - q) ? 2'b10 : 2'b01);
        if (r.hv) m_alive[r.hi] = 1'b0;
    endtask

    task automatic set_geom(input int x0, y0, w, h);
        g_x0 = x0; g_y0 = y0; g_bw = w; g_bh = h;
        bus.grid_x0 = CW'(x0);
        bus.grid_y0 = CW'(y0);
        bus.blk_w   = CW'(w);
        bus.blk_h   = CW'(h);
    endtask

    task automatic do_load();
        @(negedge clk);
        bus.load_level = 1'b1;
        @(negedge clk);
        bus.load_level = 1'b0;
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        m_overrun = 1'b0;
        check("load_mask", bus.alive_mask, model_mask());
        check("load_left", bus.blocks_left, model_left());
        check("load_overrun", bus.overrun, m_overrun);
        check("load_busy", bus.busy, 0);
    endtask

    // One frame; extra != 0 raises a second frame_tick in that scan cycle
    task automatic do_frame(input int bx, by, bw, bh, px, py, pw, ph, input int extra);
        res_t r;
        res_t e;
        int   k;
        @(negedge clk);
        bus.ball_x   = CW'(bx);
        bus.ball_y   = CW'(by);
        bus.ball_w   = CW'(bw);
        bus.ball_h   = CW'(bh);
        bus.paddle_x = CW'(px);
        bus.paddle_y = CW'(py);
        bus.paddle_w = CW'(pw);
        bus.paddle_h = CW'(ph);
        model_frame(bx, by, bw, bh, px, py, pw, ph, r);
        exp_q.push_back(r);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        k = 1;
        bus.frame_tick = (k == extra);
        check("busy_set", bus.busy, 1);
        while (!bus.scan_done && k < 40) begin
            @(negedge clk);
            k++;
            bus.frame_tick = (k == extra);
        end
        bus.frame_tick = 1'b0;
        if (extra != 0) m_overrun = 1'b1;
        check("latency", k, N + 2);
        e = exp_q.pop_front();
        check("hit_valid", bus.hit_valid, e.hv);
        if (e.hv) begin
            check("hit_idx", bus.hit_idx, e.hi);
            check("hit_face", bus.hit_face, e.hf);
        end
        check("paddle_hit", bus.paddle_hit, e.ph);
        if (e.ph) check("paddle_zone", bus.paddle_zone, e.zone);
        @(negedge clk);
        check("scan_done_pulse", bus.scan_done, 0);
        check("busy_clear", bus.busy, 0);
        check("alive_mask", bus.alive_mask, model_mask());
        check("blocks_left", bus.blocks_left, model_left());
        check("overrun", bus.overrun, m_overrun);
    endtask

    // load_level during a scan: no report, full grid, overrun cleared
    task automatic do_abort();
        int pulses = 0;
        @(negedge clk);
        bus.ball_x = CW'(76);
        bus.ball_y = CW'(44);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        bus.load_level = 1'b1;
        @(negedge clk);
        bus.load_level = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.scan_done || bus.hit_valid || bus.paddle_hit) pulses++;
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        m_overrun = 1'b0;
        check("abort_pulses", pulses, 0);
        check("abort_mask", bus.alive_mask, model_mask());
        check("abort_overrun", bus.overrun, 0);
        check("abort_busy", bus.busy, 0);
    endtask

    // Stimulus
    initial begin
        int bx, by, bw, bh, px, pw;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.frame_tick = 1'b0;
        bus.load_level = 1'b0;
        bus.ball_x = '0; bus.ball_y = '0; bus.ball_w = CW'(8); bus.ball_h = CW'(8);
        bus.paddle_x = '0; bus.paddle_y = '0; bus.paddle_w = '0; bus.paddle_h = '0;
        set_geom(32, 40, 96, 16);
        for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
        m_overrun = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mask", bus.alive_mask, 10'h3FF);
        check("rst_left", bus.blocks_left, N);
        check("rst_busy", bus.busy, 0);
        check("rst_hit_valid", bus.hit_valid, 0);
        check("rst_paddle_hit", bus.paddle_hit, 0);
        check("rst_scan_done", bus.scan_done, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_hit_idx", bus.hit_idx, 0);
        rst = 1'b0;
        do_load();

        // Directed brick and paddle frames
        do_frame(170, 44, 8, 8, 280, 440, 80, 8, 0);
        do_frame(76, 44, 8, 8, 280, 440, 80, 8, 0);
        do_frame(60, 58, 8, 8, 280, 440, 80, 8, 0);
        do_frame(284, 436, 8, 8, 280, 440, 80, 8, 0);
        do_frame(316, 436, 8, 8, 280, 440, 80, 8, 0);
        do_frame(352, 436, 8, 8, 280, 440, 80, 8, 0);
        do_frame(262, 436, 8, 8, 280, 440, 80, 8, 0);

        // Overrun, then abort by load_level
        do_frame(600, 300, 8, 8, 280, 440, 80, 8, 3);
        do_abort();

        // Bricks at the right screen edge: no wrap in the overlap sums
        set_geom(448, 40, 64, 16);
        do_load();
        do_frame(1020, 44, 8, 8, 0, 440, 80, 8, 0);
        do_frame(1000, 100, 8, 8, 0, 440, 80, 8, 0);
        set_geom(32, 40, 96, 16);

        // Clear every brick, then scan an empty grid
        do_load();
        for (int i = 0; i < N; i++) begin
            do_frame(32 + (i % NC) * PX + 44, 40 + (i / NC) * PY + 4, 8, 8, 280, 440, 80, 8, 0);
        end
        do_frame(76, 44, 8, 8, 280, 440, 80, 8, 0);
        do_frame(300, 436, 8, 8, 280, 440, 80, 8, 0);

        // Random frames
        do_load();
        for (int f = 0; f < 32; f++) begin
            if (f % 8 == 7) do_load();
            bw = int'($urandom_range(2, 20));
            bh = int'($urandom_range(2, 20));
            px = int'($urandom_range(20, 800));
            pw = int'($urandom_range(8, 120));
            if ($urandom_range(0, 1) == 0) begin
                bx = int'($urandom_range(0, 700));
                by = int'($urandom_range(20, 110));
            end else begin
                bx = int'($urandom_range(px - 10, px + pw + 10));
                by = int'($urandom_range(430, 446));
            end
            do_frame(bx, by, bw, bh, px, 440, pw, 8, ($urandom_range(0, 5) == 0) ? 3 : 0);
        end

        // Asynchronous reset in the middle of a scan
        do_load();
        do_frame(76, 44, 8, 8, 280, 440, 80, 8, 3);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_mask", bus.alive_mask, 10'h3FF);
        check("midrst_left", bus.blocks_left, N);
        check("midrst_overrun", bus.overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_done", bus.scan_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
